// File: rtl/counter_sched_pkg.sv
// Shared encodings for the counter scheduler: FSM states, owner ids, default width.
package counter_sched_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic OWN_A = 1'b0;
  localparam logic OWN_B = 1'b1;

endpackage

// File: rtl/step_counter.sv
// Clearable up-counter; clear beats enable.
module step_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  // Synchronous reset, then clear, then step.
  always_ff @(posedge clk) begin
    if (rst)      q <= '0;
    else if (clr) q <= '0;
    else if (en)  q <= q + WIDTH'(1);
  end

endmodule

// File: rtl/counter_scheduler.sv
// Round-robin owner of one shared step counter for requesters A and B.
// All outputs decode registered state/owner/count only.
module counter_scheduler
  import counter_sched_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic [WIDTH-1:0] len_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] len_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             done_a,
  output logic             done_b,
  output logic             busy,
  output logic [WIDTH-1:0] count_out
);

  state_e           state, state_nxt;
  logic             owner, owner_nxt;
  logic             last_owner, last_nxt;
  logic [WIDTH-1:0] len_q;
  logic [WIDTH-1:0] count;
  logic             cnt_clr, cnt_en, len_ld;
  logic             own_req;
  logic [WIDTH-1:0] own_len;

  assign own_req = (owner == OWN_B) ? req_b : req_a;
  assign own_len = (owner == OWN_B) ? len_b : len_a;

  step_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .q   (count)
  );

  // State, owner and tie-break history registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= OWN_A;
      last_owner <= OWN_B;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_owner <= last_nxt;
    end
  end

  // Run length is captured once, on the grant cycle.
  always_ff @(posedge clk) begin
    if (rst)         len_q <= '0;
    else if (len_ld) len_q <= own_len;
  end

  // Next-state, arbitration and counter control. Dropping the owner's
  // request in GRANT/RUN aborts: counter frozen, no done, other side wins next tie.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    last_nxt  = last_owner;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    len_ld    = 1'b0;
    case (state)
      IDLE: begin
        if (req_a && req_b) begin
          owner_nxt = ~last_owner;
          state_nxt = GRANT;
        end else if (req_a) begin
          owner_nxt = OWN_A;
          state_nxt = GRANT;
        end else if (req_b) begin
          owner_nxt = OWN_B;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (!own_req) begin
          state_nxt = IDLE;
          last_nxt  = owner;
        end else begin
          cnt_clr   = 1'b1;
          len_ld    = 1'b1;
          state_nxt = (own_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (!own_req) begin
          state_nxt = IDLE;
          last_nxt  = owner;
        end else begin
          cnt_en = 1'b1;
          if (count == len_q - WIDTH'(1)) state_nxt = DONE;
        end
      end
      DONE: begin
        last_nxt  = owner;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign gnt_a     = busy && (owner == OWN_A);
  assign gnt_b     = busy && (owner == OWN_B);
  assign done_a    = (state == DONE) && (owner == OWN_A);
  assign done_b    = (state == DONE) && (owner == OWN_B);
  assign count_out = count;

endmodule

// File: tb/tb_counter_scheduler.sv
// Scoreboard bench: stimulus queues per-cycle output snapshots and done events,
// a negedge monitor pops and compares them.
module tb_counter_scheduler;
  import counter_sched_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_a = 1'b0, req_b = 1'b0;
  logic [W-1:0] len_a = '0, len_b = '0;
  logic         gnt_a, gnt_b, done_a, done_b, busy;
  logic [W-1:0] count_out;

  counter_scheduler #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_a     (req_a),
    .len_a     (len_a),
    .req_b     (req_b),
    .len_b     (len_b),
    .gnt_a     (gnt_a),
    .gnt_b     (gnt_b),
    .done_a    (done_a),
    .done_b    (done_b),
    .busy      (busy),
    .count_out (count_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // snapshot word: {gnt_a, gnt_b, done_a, done_b, busy, count}
  typedef struct { int at; logic [W+4:0] v; } snap_t;
  typedef struct { int at; logic who; logic [W-1:0] cnt; } done_t;

  snap_t        snap_q[$];
  done_t        done_q[$];
  int           checks = 0, errors = 0;
  bit           stim_end = 1'b0;
  logic [W-1:0] exp_cnt = '0;

  function automatic logic [W+4:0] mk(input logic ga, input logic gb, input logic da,
                                      input logic db, input logic bsy, input logic [W-1:0] c);
    return {ga, gb, da, db, bsy, c};
  endfunction

  task automatic push_snap(input int at, input logic [W+4:0] v);
    snap_t s;
    s.at = at; s.v = v;
    snap_q.push_back(s);
  endtask

  // GRANT at t, RUN t+1..t+len, DONE at t+1+len.
  task automatic push_run(input logic who, input int len, input int t, input logic [W-1:0] prev);
    logic  ga, gb;
    done_t d;
    ga = (who == OWN_A);
    gb = (who == OWN_B);
    push_snap(t, mk(ga, gb, 1'b0, 1'b0, 1'b1, prev));
    for (int k = 0; k < len; k++) push_snap(t + 1 + k, mk(ga, gb, 1'b0, 1'b0, 1'b1, W'(k)));
    push_snap(t + 1 + len, mk(ga, gb, ga, gb, 1'b1, W'(len)));
    d.at = t + 1 + len; d.who = who; d.cnt = W'(len);
    done_q.push_back(d);
  endtask

  task automatic go(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic who, input logic r, input logic [W-1:0] l);
    if (who == OWN_A) begin req_a = r; len_a = l; end
    else              begin req_b = r; len_b = l; end
  endtask

  // Single uncontested request, dropped on its done cycle.
  task automatic run_req(input logic who, input int len);
    int t;
    t = cyc + 1;
    drive(who, 1'b1, W'(len));
    push_run(who, len, t, exp_cnt);
    push_snap(t + 2 + len, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, W'(len)));
    exp_cnt = W'(len);
    go(len + 2);
    drive(who, 1'b0, W'(len));
    go(2);
  endtask

  initial begin
    int t;
    go(2);
    push_snap(cyc, '0);
    rst = 1'b0;

    // Tie from reset: A, B, A, done pulses 5 cycles apart.
    t = cyc + 1;
    req_a = 1'b1; len_a = 8'd2; req_b = 1'b1; len_b = 8'd2;
    push_run(OWN_A, 2, t, exp_cnt);
    push_snap(t + 4, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2));
    push_run(OWN_B, 2, t + 5, 8'd2);
    push_snap(t + 9, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2));
    push_run(OWN_A, 2, t + 10, 8'd2);
    push_snap(t + 14, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2));
    exp_cnt = 8'd2;
    go(9);  req_b = 1'b0;
    go(5);  req_a = 1'b0;
    go(2);

    // Abort: A len 10 drops at count 4; B (raised mid-run) granted next.
    t = cyc + 1;
    req_a = 1'b1; len_a = 8'd10;
    push_snap(t, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, exp_cnt));
    for (int k = 0; k <= 4; k++) push_snap(t + 1 + k, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, W'(k)));
    push_snap(t + 6, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd4));
    push_run(OWN_B, 1, t + 7, 8'd4);
    push_snap(t + 10, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1));
    go(2);  req_b = 1'b1; len_b = 8'd1;
    go(4);  req_a = 1'b0;
    go(4);  req_b = 1'b0;
    go(2);
    exp_cnt = 8'd1;

    // Plain run, and zero-length run.
    run_req(OWN_A, 3);
    run_req(OWN_B, 0);

    // Reset at count 7 with request still high: no done, all outputs cleared.
    t = cyc + 1;
    req_a = 1'b1; len_a = 8'd20;
    push_snap(t, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, exp_cnt));
    for (int k = 0; k <= 7; k++) push_snap(t + 1 + k, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, W'(k)));
    push_snap(t + 9, '0);
    push_snap(t + 10, '0);
    go(9);  rst = 1'b1;
    go(1);  rst = 1'b0; req_a = 1'b0;
    go(2);
    exp_cnt = '0;

    // Full-range run: counts to 255 without wrap, 257 cycles occupied.
    run_req(OWN_A, 255);

    go(2);
    stim_end = 1'b1;
  end

  done_t        dcur;
  snap_t        scur;
  logic [W+4:0] obs;

  // Monitor: pops expectations and compares against what the DUT presents.
  always @(negedge clk) begin
    if (done_q.size() > 0 && done_q[0].at < cyc) begin
      dcur = done_q.pop_front();
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL done_missing: got no done pulse, required owner %0d count %0d at cycle %0d",
               dcur.who, dcur.cnt, dcur.at);
    end
    if (done_a || done_b) begin
      checks = checks + 1;
      if (done_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL done_unexpected: got done_a=%0b done_b=%0b count=%0d at cycle %0d, required none",
                 done_a, done_b, count_out, cyc);
      end else begin
        dcur = done_q.pop_front();
        if (dcur.at != cyc || (done_a && done_b) || done_b != dcur.who || count_out != dcur.cnt) begin
          errors = errors + 1;
          $display("FAIL done_event: got a=%0b b=%0b count=%0d cycle=%0d, required owner=%0d count=%0d cycle=%0d",
                   done_a, done_b, count_out, cyc, dcur.who, dcur.cnt, dcur.at);
        end
      end
    end
    while (snap_q.size() > 0 && snap_q[0].at <= cyc) begin
      scur = snap_q.pop_front();
      obs = {gnt_a, gnt_b, done_a, done_b, busy, count_out};
      checks = checks + 1;
      if (scur.at != cyc || obs !== scur.v) begin
        errors = errors + 1;
        $display("FAIL snapshot@%0d: got {ga,gb,da,db,busy,cnt}=%b_%0d, required %b_%0d (cycle %0d)",
                 scur.at, obs[W+4:W], obs[W-1:0], scur.v[W+4:W], scur.v[W-1:0], cyc);
      end
    end
    if (stim_end) begin
      checks = checks + 1;
      if (snap_q.size() != 0 || done_q.size() != 0) begin
        errors = errors + 1;
        $display("FAIL leftover: got %0d snapshots and %0d done events unchecked, required 0",
                 snap_q.size(), done_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  initial begin
    #3000000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
